branch_predictor: RTL
=====================

# branch_predictor

Branch predictor feeding the instruction fetch stage. It holds a direct-mapped branch target buffer with 2-bit saturating direction counters. It looks up the fetch stage's next program counter each cycle and drives a registered redirect (`target_bp`, `target_en_bp`) that fetch consumes on the following cycle. Execute writes resolved branch outcomes back through an update port.

## Interface
Parameters:
- `INDEX_BITS`, default 4: BTB index width; 2^INDEX_BITS entries, tag width 16-INDEX_BITS.

Ports:
- `clk` in 1: the block's single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `next_program_counter_if_to_bp` in 16: fetch stage NPC; lookup address.
- `flush` in 1: squashes the prediction being registered this cycle (execute redirect).
- `update_en` in 1: resolved branch update valid.
- `update_pc` in 16: address of the resolved branch.
- `update_taken` in 1: resolved direction.
- `update_target` in 16: resolved taken target.
- `target_bp` out 16: predicted next-fetch address, registered.
- `target_en_bp` out 1: prediction valid and taken, registered.
- `lookup_count` out 16: present only with `BP_STATS_EN`.
- `taken_count` out 16: present only with `BP_STATS_EN`.

## Operation
- Index is `pc[INDEX_BITS-1:0]`; tag is `pc[15:INDEX_BITS]`.
- Each entry holds `valid`, `tag`, 16-bit `target` and 2-bit `ctr`.
- Counter encoding: 0 = strong not-taken, 1 = weak not-taken, 2 = weak taken, 3 = strong taken.
- Lookup is performed every cycle on the NPC.
  - `hit` = `valid && tag match && ctr[1]`.
  - On the clock edge, `target_en_bp <= hit && !flush`.
  - On the clock edge, `target_bp <= entry.target`. When `hit` is 0, `target_bp` takes the entry's target anyway; it is don't-care while `target_en_bp` is 0.
- Update, applied on the clock edge when `update_en` is high:
  - Tag hit on a valid entry: `ctr` increments if taken, saturating at 3; decrements if not taken, saturating at 0. On taken, `target <= update_target`.
  - Miss or invalid entry with taken: allocate the entry with `valid=1`, the new tag, `target=update_target`, `ctr=2`. Any previous occupant is overwritten.
  - Miss or invalid entry with not taken: no change.
- Simultaneous lookup and update to the same index: the lookup uses pre-update contents. The update becomes visible to lookups one cycle later.
- `flush` affects only the output register. It has no effect on BTB contents or on an update in the same cycle.

## Timing
- Reset (synchronous, takes effect at the edge while `rst`=1):
  - All `valid` bits cleared and all `ctr` set to 1.
  - `target_en_bp`=0, `target_bp`=16'h0000.
  - Stats counters cleared to 0.
  - Updates presented during reset are dropped.
- Lookup latency is 1 cycle. NPC sampled at edge t produces the prediction visible during cycle t+1, where fetch uses it as the successor of the instruction at PC(t+1) = NPC(t).
- There is no combinational path from `next_program_counter_if_to_bp` to any output. This is required so that the loop through fetch's NPC adder stays broken.
- Update latency is 1 cycle to BTB state. An update at edge t influences a lookup sampled at edge t+1.
- Reset mid-operation: the prediction in flight is dropped; `target_en_bp` is 0 in the cycle after reset.

## Configuration
- `BP_STATS_EN` defined:
  - `lookup_count` increments every non-reset cycle in which `flush`=0.
  - `taken_count` increments when `hit && !flush`.
  - Both are 16-bit registers that saturate at 16'hFFFF and do not wrap.
- `BP_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package `bp_pkg` contains:
  - `BP_INDEX_BITS_DEFAULT`.
  - Counter constants `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - Typedef `bp_entry_t` (valid, tag, target, ctr).
  - Saturating increment/decrement functions.
- One sub-module, `bp_sat_counter`, is the 2-bit saturating next-state logic. It takes the current value and a taken flag and returns the next value; it is instantiated once on the update path.

## Test plan
- Reset, then NPC=16'h0010 for 3 cycles → `target_en_bp`=0 every cycle; `target_bp`=16'h0000 after reset.
- Update `pc=16'h0010`, taken, target 16'h0040; next cycle NPC=16'h0010 → the following cycle shows `target_en_bp`=1, `target_bp`=16'h0040.
- Same entry, two not-taken updates (ctr 2→1→0) → lookup gives `target_en_bp`=0. Then three taken updates → ctr reaches 3 and stays 3 after a fourth taken update.
- Aliasing: allocate 16'h0010→16'h0040, then taken update at 16'h0020 (same index when INDEX_BITS=4) → lookup 16'h0010 misses (`target_en_bp`=0); lookup 16'h0020 hits.
- Same-edge update (allocate 16'h0005→16'h0100) and lookup of 16'h0005 → no prediction next cycle; the repeat lookup one cycle later predicts 16'h0100. With `flush`=1 on a hitting lookup → `target_en_bp`=0.
- With `BP_STATS_EN`: preload `lookup_count` near saturation by running 65540 unflushed cycles → it reads 16'hFFFF and holds. Reset → both counters read 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch predictor: counter encoding,
// BTB entry layout and saturating counter arithmetic.
package bp_pkg;

  localparam int unsigned BP_INDEX_BITS_DEFAULT = 4;

  // 2-bit direction counter encoding; bit 1 set means predict taken.
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Tag is kept at full 16-bit width as pc >> INDEX_BITS so the entry type
  // does not depend on the index width; the upper bits are simply zero.
  typedef struct packed {
    logic        valid;
    logic [15:0] tag;
    logic [15:0] target;
    logic [1:0]  ctr;
  } bp_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
// Stats outputs exist only when BP_STATS_EN is defined.
interface branch_predictor_if;
  logic [15:0] next_program_counter_if_to_bp;
  logic        flush;
  logic        update_en;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic [15:0] target_bp;
  logic        target_en_bp;
`ifdef BP_STATS_EN
  logic [15:0] lookup_count;
  logic [15:0] taken_count;

  modport master (
    output next_program_counter_if_to_bp, flush, update_en, update_pc, update_taken,
           update_target,
    input  target_bp, target_en_bp, lookup_count, taken_count
  );
  modport slave (
    input  next_program_counter_if_to_bp, flush, update_en, update_pc, update_taken,
           update_target,
    output target_bp, target_en_bp, lookup_count, taken_count
  );
`else
  modport master (
    output next_program_counter_if_to_bp, flush, update_en, update_pc, update_taken,
           update_target,
    input  target_bp, target_en_bp
  );
  modport slave (
    input  next_program_counter_if_to_bp, flush, update_en, update_pc, update_taken,
           update_target,
    output target_bp, target_en_bp
  );
`endif
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating direction counter next-state logic.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Move toward the resolved direction, clamping at either end.
  always_comb begin
    ctr_o = taken_i ? sat_inc(ctr_i) : sat_dec(ctr_i);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit direction counters and a
// registered redirect to fetch. Optional stats counters under BP_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = BP_INDEX_BITS_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int unsigned Entries = 1 << INDEX_BITS;

  bp_entry_t btb_q [Entries];
  bp_entry_t btb_d [Entries];

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  bp_entry_t             lk_entry, up_entry;
  logic                  lk_hit, up_hit;
  logic [1:0]            up_ctr_next;

  logic [15:0] target_q, target_d;
  logic        target_en_q, target_en_d;

  assign lk_idx   = bp.next_program_counter_if_to_bp[INDEX_BITS-1:0];
  assign up_idx   = bp.update_pc[INDEX_BITS-1:0];
  assign lk_entry = btb_q[lk_idx];
  assign up_entry = btb_q[up_idx];

  bp_sat_counter u_sat_counter (
    .ctr_i   (up_entry.ctr),
    .taken_i (bp.update_taken),
    .ctr_o   (up_ctr_next)
  );

  // Lookup on registered BTB contents; same-edge updates are not visible yet.
  always_comb begin
    lk_hit = lk_entry.valid && (lk_entry.tag == (bp.next_program_counter_if_to_bp >> INDEX_BITS))
             && lk_entry.ctr[1];
    target_en_d = lk_hit && !bp.flush;
    target_d    = lk_entry.target;
  end

  // BTB next state: train on a tag hit, allocate on a taken miss.
  always_comb begin
    btb_d  = btb_q;
    up_hit = up_entry.valid && (up_entry.tag == (bp.update_pc >> INDEX_BITS));
    if (bp.update_en) begin
      if (up_hit) begin
        btb_d[up_idx].ctr = up_ctr_next;
        if (bp.update_taken) btb_d[up_idx].target = bp.update_target;
      end else if (bp.update_taken) begin
        btb_d[up_idx] = '{valid: 1'b1, tag: bp.update_pc >> INDEX_BITS,
                          target: bp.update_target, ctr: CTR_WT};
      end
    end
  end

  // State registers; reset drops any update and the in-flight prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Entries); i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
      target_q    <= 16'h0000;
      target_en_q <= 1'b0;
    end else begin
      btb_q       <= btb_d;
      target_q    <= target_d;
      target_en_q <= target_en_d;
    end
  end

  assign bp.target_bp    = target_q;
  assign bp.target_en_bp = target_en_q;

`ifdef BP_STATS_EN
  logic [15:0] lookup_count_q, lookup_count_d;
  logic [15:0] taken_count_q, taken_count_d;

  // Saturating event counters.
  always_comb begin
    lookup_count_d = lookup_count_q;
    taken_count_d  = taken_count_q;
    if (!bp.flush && lookup_count_q != 16'hFFFF) lookup_count_d = lookup_count_q + 16'd1;
    if (target_en_d && taken_count_q != 16'hFFFF) taken_count_d = taken_count_q + 16'd1;
  end

  // Stats registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_count_q <= 16'h0000;
      taken_count_q  <= 16'h0000;
    end else begin
      lookup_count_q <= lookup_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign bp.lookup_count = lookup_count_q;
  assign bp.taken_count  = taken_count_q;
`endif

endmodule
